simon_playback_sequencer: RTL and testbench

- Sequences the Simon pattern memory during PLAYBACK mode.
- On a start pulse, walks addresses 0..pattern_count-1, fetches each stored pattern through a 1-cycle synchronous read port and shows it on the colour LEDs for a fixed hold time, then blanks the LEDs for a gap.
- Reports completion to the top-level Simon control FSM, which then enters REPEAT mode.

---
 rtl/simon_playback_sequencer_if.sv | 14 +
 rtl/simon_playback_sequencer.sv | 173 +++++++++++++++++
 tb/tb_simon_playback_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/simon_playback_sequencer_if.sv
// Pattern memory read port between the playback sequencer and the Simon
// pattern RAM. The sequencer is the master: it drives rd_en and rd_addr, and
// the RAM returns rd_data one cycle later.
interface simon_playback_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) ();
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/simon_playback_sequencer.sv
// Simon playback sequencer.
// After a start pulse it reads patterns 0..pattern_count-1 from the pattern
// memory. Each pattern is lit on the LEDs for a hold time and then blanked for
// a gap. A one-cycle done pulse is raised when the last gap ends.
// Optional feature: define SIMON_PLAYBACK_SPEEDUP_EN to shorten the hold time
// as more patterns are stored. The hold is max(MIN_HOLD,
// HOLD_CYCLES - count*SPEEDUP_STEP).
module simon_playback_sequencer #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 4,
    parameter int CNT_W        = 16,
    parameter int HOLD_CYCLES  = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int SPEEDUP_STEP = 1,
    parameter int MIN_HOLD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [ADDR_W:0]              i_pattern_count,
    simon_playback_sequencer_if.master   mem_if,
    output logic [DATA_W-1:0]            o_leds_out,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [ADDR_W-1:0]            o_step_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]        r_state;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_step_idx;
    logic [CNT_W-1:0]  r_timer;
    logic [DATA_W-1:0] r_pattern;

    logic [CNT_W-1:0]  w_hold_m1;
    logic [ADDR_W:0]   w_count_m1;
    logic              w_last_step;
    logic              w_accept;

    // A start is taken only from IDLE. An abort in the same cycle wins.
    assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;

    // count-1 is kept one bit wider than step_idx. A full memory
    // (count = 2^ADDR_W) therefore ends on the last address, and step_idx
    // never wraps.
    assign w_count_m1  = r_count - 1'b1;
    assign w_last_step = ({1'b0, r_step_idx} == w_count_m1);

`ifdef SIMON_PLAYBACK_SPEEDUP_EN
    localparam int PROD_W = CNT_W + ADDR_W + 1;

    logic [CNT_W-1:0]  r_hold_m1;
    logic [PROD_W-1:0] w_hold_base;
    logic [PROD_W-1:0] w_reduction;
    logic [PROD_W-1:0] w_hold_floor;
    logic [PROD_W-1:0] w_hold_sel;

    assign w_hold_base  = PROD_W'(HOLD_CYCLES);
    assign w_hold_floor = PROD_W'(MIN_HOLD);
    assign w_reduction  = PROD_W'(i_pattern_count) * PROD_W'(SPEEDUP_STEP);
    // Subtract only when the reduction is smaller than the base.
    // This stops the unsigned difference from wrapping around.
    assign w_hold_sel   = ((w_reduction < w_hold_base) &&
                           ((w_hold_base - w_reduction) > w_hold_floor))
                          ? (w_hold_base - w_reduction) : w_hold_floor;

    // Fix the shortened hold time for the whole playback when start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_m1 <= '0;
        end else if (w_accept) begin
            r_hold_m1 <= CNT_W'(w_hold_sel - 1'b1);
        end
    end

    assign w_hold_m1 = r_hold_m1;
`else
    assign w_hold_m1 = CNT_W'(HOLD_CYCLES - 1);
`endif

    // Playback state machine with its step index, hold/gap timer and latched pattern.
    always_ff @(posedge clk) begin
        // NOTE: every register in this block uses non-blocking assignment.
        // All of them then update together from the values before the edge.
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_step_idx <= '0;
            r_timer    <= '0;
            r_pattern  <= '0;
        end else if (i_abort && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_step_idx <= '0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count    <= i_pattern_count;
                        r_step_idx <= '0;
                        r_state    <= (i_pattern_count == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_pattern <= mem_if.rd_data;
                    r_timer   <= w_hold_m1;
                    r_state   <= S_SHOW;
                end
                S_SHOW: begin
                    if (r_timer == '0) begin
                        r_timer <= GAP_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        if (w_last_step) begin
                            r_state <= S_DONE;
                        end else begin
                            r_step_idx <= r_step_idx + 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_DONE: begin
                    r_step_idx <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_step_idx <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from the current state only.
    always_comb begin
        // NOTE: each output gets a default first.
        // Every path then assigns it, so no latch is inferred.
        o_leds_out     = '0;
        mem_if.rd_en   = 1'b0;
        mem_if.rd_addr = '0;
        if (r_state == S_SHOW) begin
            o_leds_out = r_pattern;
        end
        if (r_state == S_FETCH) begin
            mem_if.rd_en   = 1'b1;
            mem_if.rd_addr = r_step_idx;
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_step_idx = r_step_idx;

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Self-checking bench for simon_playback_sequencer.
// A timeline model predicts every output on every cycle of a playback. It
// works from the step period (2 + hold + gap), the step number and the offset
// within the step.
module tb_simon_playback_sequencer;

    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 4;
    localparam int CNT_W        = 16;
    localparam int HOLD_CYCLES  = 4;
    localparam int GAP_CYCLES   = 2;
    localparam int SPEEDUP_STEP = 1;
    localparam int MIN_HOLD     = 2;
    localparam int DEPTH        = 2 ** ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] leds;
        logic              busy;
        logic              done;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic [ADDR_W-1:0] step;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   pattern_count;
    logic [DATA_W-1:0] leds;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] step_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    int n_assert = 0;
    int n_fail   = 0;

    simon_playback_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    simon_playback_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .HOLD_CYCLES(HOLD_CYCLES), .GAP_CYCLES(GAP_CYCLES),
        .SPEEDUP_STEP(SPEEDUP_STEP), .MIN_HOLD(MIN_HOLD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (start),
        .i_abort         (abort),
        .i_pattern_count (pattern_count),
        .mem_if          (mem_bus.master),
        .o_leds_out      (leds),
        .o_busy          (busy),
        .o_done          (done),
        .o_step_idx      (step_idx)
    );

    always #5 clk = ~clk;

    // Synchronous pattern RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_bus.rd_en) mem_bus.rd_data <= mem[mem_bus.rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_hold(input int c);
        int h;
`ifdef SIMON_PLAYBACK_SPEEDUP_EN
        h = HOLD_CYCLES - c * SPEEDUP_STEP;
        if (h < MIN_HOLD) h = MIN_HOLD;
`else
        h = HOLD_CYCLES;
`endif
        return h;
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e = '{leds: '0, busy: 1'b0, done: 1'b0, rd_en: 1'b0, rd_addr: '0, step: '0};
        return e;
    endfunction

    // Expected outputs t cycles after the start cycle.
    function automatic obs_t expect_at(input int t, input int c, input int hold);
        obs_t e;
        int   period, done_cyc, k, o;
        e        = idle_obs();
        period   = 2 + hold + GAP_CYCLES;
        done_cyc = (c == 0) ? 1 : 1 + c * period;
        if (t < 1 || t > done_cyc) return e;
        e.busy = 1'b1;
        if (t == done_cyc) begin
            e.done = 1'b1;
            e.step = (c == 0) ? '0 : ADDR_W'(c - 1);
            return e;
        end
        k      = (t - 1) / period;
        o      = (t - 1) % period;
        e.step = ADDR_W'(k);
        if (o == 0) begin
            e.rd_en   = 1'b1;
            e.rd_addr = ADDR_W'(k);
        end else if (o >= 2 && o < 2 + hold) begin
            e.leds = mem[k];
        end
        return e;
    endfunction

    task automatic compare_all(input string tag, input obs_t e);
        check({tag, ".leds"},    32'(leds),             32'(e.leds));
        check({tag, ".busy"},    32'(busy),             32'(e.busy));
        check({tag, ".done"},    32'(done),             32'(e.done));
        check({tag, ".rd_en"},   32'(mem_bus.rd_en),    32'(e.rd_en));
        check({tag, ".rd_addr"}, 32'(mem_bus.rd_addr),  32'(e.rd_addr));
        check({tag, ".step"},    32'(step_idx),         32'(e.step));
    endtask

    // One playback of c patterns, entered from IDLE.
    // If abort_at >= 0, abort is raised in that cycle.
    // If junk is set, extra start pulses and pattern_count changes are driven while busy.
    task automatic run_trial(input string tag, input int c, input int abort_at, input bit junk);
        int   hold, done_cyc;
        obs_t e;
        hold          = model_hold(c);
        done_cyc      = (c == 0) ? 1 : 1 + c * (2 + hold + GAP_CYCLES);
        start         = 1'b1;
        abort         = 1'b0;
        pattern_count = (ADDR_W+1)'(c);
        for (int t = 1; t <= done_cyc + 2; t++) begin
            @(posedge clk);
            #1;
            if (abort_at >= 0 && t > abort_at) e = idle_obs();
            else                               e = expect_at(t, c, hold);
            compare_all($sformatf("%s@%0d", tag, t), e);
            start = junk && (t < done_cyc) && (abort_at < 0 || t <= abort_at)
                    && ($urandom_range(0, 2) == 0);
            pattern_count = junk ? (ADDR_W+1)'($urandom_range(0, DEPTH)) : (ADDR_W+1)'(c);
            abort = (t == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int c, abort_at, period;
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        pattern_count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset", idle_obs());
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic three-pattern playback.
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        run_trial("basic", 3, -1, 1'b0);
        // An empty pattern memory goes straight to a done pulse.
        run_trial("empty", 0, -1, 1'b0);
        // Abort during the second SHOW.
        run_trial("abort", 3, 12, 1'b0);
        // Re-pulses of start and pattern_count changes while busy are ignored.
        run_trial("restart", 3, -1, 1'b1);

        // start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1; pattern_count = 3;
        @(posedge clk); #1;
        compare_all("start_abort", idle_obs());
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        compare_all("start_abort2", idle_obs());

        // Reset in the middle of a playback.
        start = 1'b1; pattern_count = 2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid.busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        compare_all("mid_rst", idle_obs());
        @(posedge clk); #1;
        compare_all("mid_rst2", idle_obs());

        // Full memory: every address is played and step_idx does not wrap.
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(1 << $urandom_range(0, DATA_W - 1));
        run_trial("full", DEPTH, -1, 1'b0);

        // Random trials.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(1 << $urandom_range(0, DATA_W - 1));
            c      = $urandom_range(0, 6);
            period = 2 + model_hold(c) + GAP_CYCLES;
            if ($urandom_range(0, 2) == 0)
                abort_at = (c == 0) ? 1 : $urandom_range(1, 1 + c * period);
            else
                abort_at = -1;
            run_trial($sformatf("rand%0d", n), c, abort_at, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
